// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator (HSYNC/VSYNC/DE/X/Y/FRAME_START); optional colour bars under VIDEO_PATTERN_EN
`timescale 1ns/1ps
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int CNT_W    = 10
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             PX_EN,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             DE,
    output logic [CNT_W-1:0] X,
    output logic [CNT_W-1:0] Y,
    output logic             FRAME_START
`ifdef VIDEO_PATTERN_EN
    ,
    output logic [23:0]      RGB
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Region boundaries sized to the counters; sync ends are inclusive so they never overflow CNT_W.
    localparam logic [CNT_W-1:0] H_LAST_C    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST_C    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C     = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_LO_C = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_HI_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_SYNC_LO_C = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_HI_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             SYNC_ON     = (SYNC_POL != 0);

    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             h_wrap;
    logic             de_nxt;
    logic             hs_nxt;
    logic             vs_nxt;

    // Outputs are computed from the position the counters will hold after the edge,
    // so registered outputs line up with the counters with no extra latency.
    always_comb begin
        h_wrap = (h == H_LAST_C);
        h_nxt  = h_wrap ? '0 : h + CNT_W'(1);
        v_nxt  = v;
        if (h_wrap) begin
            v_nxt = (v == V_LAST_C) ? '0 : v + CNT_W'(1);
        end
        de_nxt = (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
        hs_nxt = ((h_nxt >= H_SYNC_LO_C) && (h_nxt <= H_SYNC_HI_C)) ? SYNC_ON : ~SYNC_ON;
        vs_nxt = ((v_nxt >= V_SYNC_LO_C) && (v_nxt <= V_SYNC_HI_C)) ? SYNC_ON : ~SYNC_ON;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            h           <= H_LAST_C;
            v           <= V_LAST_C;
            HSYNC       <= ~SYNC_ON;
            VSYNC       <= ~SYNC_ON;
            DE          <= 1'b0;
            X           <= '0;
            Y           <= '0;
            FRAME_START <= 1'b0;
        end else begin
            FRAME_START <= PX_EN && h_wrap && (v == V_LAST_C);
            if (PX_EN) begin
                h     <= h_nxt;
                v     <= v_nxt;
                HSYNC <= hs_nxt;
                VSYNC <= vs_nxt;
                DE    <= de_nxt;
                X     <= de_nxt ? h_nxt : '0;
                Y     <= de_nxt ? v_nxt : '0;
            end
        end
    end

`ifdef VIDEO_PATTERN_EN
    localparam int               BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    localparam logic [CNT_W-1:0] BAR_W_C = CNT_W'(BAR_W);

    logic [CNT_W-1:0] bar_div;
    logic [2:0]       bar_idx;
    logic [23:0]      bar_rgb;

    // Leftover columns when H_ACTIVE is not a multiple of 8 stay in the last bar.
    always_comb begin
        bar_div = h_nxt / BAR_W_C;
        bar_idx = (bar_div > CNT_W'(7)) ? 3'd7 : bar_div[2:0];
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            RGB <= '0;
        end else if (PX_EN) begin
            RGB <= de_nxt ? bar_rgb : 24'h000000;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen against a linear-position raster model
`timescale 1ns/1ps
module tb_video_timing_gen;

    localparam int HA = 16, HFP = 2, HS = 3, HB = 3;
    localparam int VA = 8, VFP = 1, VS = 2, VB = 2;
    localparam int HT = HA + HFP + HS + HB;
    localparam int VT = VA + VFP + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int POL = 0;
    localparam int CW = 10;

    logic          CLK = 1'b0;
    logic          RST_n;
    logic          PX_EN;
    logic          HSYNC, VSYNC, DE, FRAME_START;
    logic [CW-1:0] X, Y;
    logic [23:0]   rgb_act;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(POL), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .PX_EN(PX_EN),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE),
        .X(X), .Y(Y), .FRAME_START(FRAME_START)
`ifdef VIDEO_PATTERN_EN
        , .RGB(rgb_act)
`endif
    );

`ifndef VIDEO_PATTERN_EN
    assign rgb_act = 24'h000000;
`endif

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          fs;
        logic [23:0]   rgb;
    } obs_t;

    obs_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          p;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // Position p counts pixels linearly through the frame; (h,v) fall out of div/mod.
    function automatic obs_t model(input int pos, input logic fs);
        obs_t o;
        int h, v, idx;
        h = pos % HT;
        v = pos / HT;
        o.de  = (h < HA) && (v < VA);
        o.hs  = (h >= HA + HFP && h < HA + HFP + HS) ? logic'(POL) : !logic'(POL);
        o.vs  = (v >= VA + VFP && v < VA + VFP + VS) ? logic'(POL) : !logic'(POL);
        o.x   = o.de ? CW'(h) : '0;
        o.y   = o.de ? CW'(v) : '0;
        o.fs  = fs;
        o.rgb = 24'h000000;
`ifdef VIDEO_PATTERN_EN
        if (o.de) begin
            idx = h / (HA / 8);
            if (idx > 7) idx = 7;
            o.rgb = bars[idx];
        end
`endif
        return o;
    endfunction

    function automatic obs_t reset_obs();
        obs_t o;
        o    = '0;
        o.hs = !logic'(POL);
        o.vs = !logic'(POL);
        return o;
    endfunction

    task automatic step(input logic px, input logic rst_lo);
        logic fs;
        @(negedge CLK);
        PX_EN = px;
        RST_n = !rst_lo;
        @(posedge CLK);
        if (rst_lo) begin
            p = FRAME - 1;
            exp_q.push_back(reset_obs());
        end else begin
            fs = 1'b0;
            if (px) begin
                fs = (p == FRAME - 1);
                p  = (p + 1) % FRAME;
            end
            exp_q.push_back(model(p, fs));
        end
    endtask

    // Runs to a chosen mid-frame position, then drops reset between clock edges.
    task automatic async_reset(input int target);
        for (int i = 0; i < 2 * FRAME && p != target; i++) step(1'b1, 1'b0);
        @(negedge CLK);
        PX_EN = logic'($urandom_range(0, 1));
        #2;
        RST_n = 1'b0;
        p = FRAME - 1;
        exp_q.push_back(reset_obs());
        @(posedge CLK);
        exp_q.push_back(reset_obs());
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
    endtask

    initial begin
        obs_t e, a;
        forever begin
            @(posedge CLK or negedge RST_n);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {HSYNC, VSYNC, DE, X, Y, FRAME_START, rgb_act};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL sample t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d fs=%b rgb=%h required hs=%b vs=%b de=%b x=%0d y=%0d fs=%b rgb=%h",
                             $time, a.hs, a.vs, a.de, a.x, a.y, a.fs, a.rgb,
                             e.hs, e.vs, e.de, e.x, e.y, e.fs, e.rgb);
                end
            end
        end
    end

    initial begin
        RST_n = 1'b0;
        PX_EN = 1'b0;
        p     = FRAME - 1;
        repeat (3) step(1'b0, 1'b1);
        for (int i = 0; i < 4 * FRAME + 40; i++) step(i % 4 == 3, 1'b0);
        for (int i = 0; i < 1500; i++) step(logic'($urandom_range(0, 1)), 1'b0);
        async_reset(5 * HT + 10);
        for (int i = 0; i < 2 * FRAME + 20; i++) step(1'b1, 1'b0);
        async_reset(3 * HT + 20);
        for (int i = 0; i < 600; i++) step(logic'($urandom_range(0, 3) != 0), 1'b0);
        async_reset(FRAME - 1);
        for (int i = 0; i < FRAME + 30; i++) step(1'b1, 1'b0);
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge CLK);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
